// File: rtl/mem_wb_stage_if.sv
// Data-cache request/response bundle between the MEM/WB stage and the cache.
// The stage holds each strobe high until the cycle the cache pulses data_mem_resp.
interface mem_wb_stage_if;
  logic        data_mem_read;
  logic        data_mem_write;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;

  modport master (
    output data_mem_read,
    output data_mem_write,
    input  data_mem_resp,
    input  data_mem_rdata
  );

  modport slave (
    input  data_mem_read,
    input  data_mem_write,
    output data_mem_resp,
    output data_mem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: drives cache strobes, stalls upstream until resp, extracts load data.
// Writeback triple is registered with 1-cycle latency once the instruction retires.
module mem_wb_stage #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [6:0]             in_opcode,
  input  logic [2:0]             in_funct3,
  input  logic [4:0]             in_rd,
  input  logic                   in_regwrite,
  input  logic [31:0]            in_alu_out,
  mem_wb_stage_if.master         dmem,
  output logic                   stall_out,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [4:0]             wb_rd,
  output logic [31:0]            wb_data,
  output logic                   misalign_err,
  output logic [STALL_CNT_W-1:0] perf_mem_stall
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                   r_wb_valid;
  logic                   r_wb_we;
  logic [4:0]             r_wb_rd;
  logic [31:0]            r_wb_data;
  logic                   r_misalign;
  logic [STALL_CNT_W-1:0] r_perf;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_memop;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic        w_aligned;
  logic        w_retire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_we_nxt;
  logic [31:0] w_data_nxt;

  assign w_is_load  = in_opcode == OP_LOAD;
  assign w_is_store = in_opcode == OP_STORE;
  assign w_memop    = in_valid & (w_is_load | w_is_store);
  assign w_off      = in_alu_out[1:0];

  // Illegal funct3 encodings are folded into the misaligned path: no access, error pulse.
  always_comb begin
    w_misalign = 1'b0;
    if (w_is_load) begin
      case (in_funct3)
        3'd0, 3'd4: w_misalign = 1'b0;
        3'd1, 3'd5: w_misalign = (w_off == 2'd3);
        3'd2:       w_misalign = (w_off != 2'd0);
        default:    w_misalign = 1'b1;
      endcase
    end else if (w_is_store) begin
      case (in_funct3)
        3'd0:    w_misalign = 1'b0;
        3'd1:    w_misalign = (w_off == 2'd3);
        3'd2:    w_misalign = (w_off != 2'd0);
        default: w_misalign = 1'b1;
      endcase
    end
  end

  assign w_aligned = w_memop & ~w_misalign;

  assign dmem.data_mem_read  = ~rst & w_aligned & w_is_load;
  assign dmem.data_mem_write = ~rst & w_aligned & w_is_store;
  assign stall_out           = ~rst & w_aligned & ~dmem.data_mem_resp;

  // A valid instruction retires this cycle unless it is a memop still waiting on the cache.
  assign w_retire = in_valid & ~stall_out;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_aligned && !dmem.data_mem_resp) w_state_nxt = ST_WAIT;
      ST_WAIT: if (dmem.data_mem_resp || !w_aligned) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_byte = dmem.data_mem_rdata[7:0];
    case (w_off)
      2'd0:    w_byte = dmem.data_mem_rdata[7:0];
      2'd1:    w_byte = dmem.data_mem_rdata[15:8];
      2'd2:    w_byte = dmem.data_mem_rdata[23:16];
      default: w_byte = dmem.data_mem_rdata[31:24];
    endcase
  end

  assign w_half = w_off[1] ? dmem.data_mem_rdata[31:16] : dmem.data_mem_rdata[15:0];

  always_comb begin
    w_load_data = dmem.data_mem_rdata;
    case (in_funct3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_load_data = {24'd0, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd5:    w_load_data = {16'd0, w_half};
      default: w_load_data = dmem.data_mem_rdata;
    endcase
  end

  always_comb begin
    w_we_nxt   = in_regwrite;
    w_data_nxt = in_alu_out;
    if (w_memop) begin
      w_we_nxt = w_aligned & w_is_load;
      if (w_aligned && w_is_load) w_data_nxt = w_load_data;
    end
    if (in_rd == 5'd0) w_we_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_misalign <= 1'b0;
      r_perf     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_valid <= w_retire;
      r_wb_we    <= w_retire & w_we_nxt;
      r_misalign <= w_retire & w_memop & w_misalign;
      if (w_retire) begin
        r_wb_rd   <= in_rd;
        r_wb_data <= w_data_nxt;
      end
      if (stall_out && (r_perf != '1)) r_perf <= r_perf + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wb_valid       = r_wb_valid;
  assign wb_we          = r_wb_we;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign misalign_err   = r_misalign;
  assign perf_mem_stall = r_perf;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a 2-bit stall counter exposes saturation.
module tb_mem_wb_stage;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [6:0]  in_opcode = 7'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_regwrite = 1'b0;
  logic [31:0] in_alu_out = 32'd0;
  logic        stall_out, wb_valid, wb_we, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  perf_mem_stall;

  int total = 0;
  int bad = 0;

  mem_wb_stage_if dmem ();

  mem_wb_stage #(.STALL_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_alu_out(in_alu_out), .dmem(dmem), .stall_out(stall_out),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .perf_mem_stall(perf_mem_stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic rw, input logic [31:0] alu);
    in_valid = v; in_opcode = op; in_funct3 = f3; in_rd = rd; in_regwrite = rw; in_alu_out = alu;
  endtask

  task automatic idle();
    set_in(1'b0, OP_ALU, 3'd0, 5'd0, 1'b0, 32'd0);
    dmem.data_mem_resp = 1'b0;
    dmem.data_mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    idle();
    #2;
    total++; if (dmem.data_mem_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", dmem.data_mem_read); end
    total++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b exp=000", wb_valid, wb_we, misalign_err); end
    total++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb got rd=%0d data=%h exp 0/0", wb_rd, wb_data); end
    total++; if (perf_mem_stall !== 2'd0) begin bad++; $display("FAIL reset_perf got=%0d exp=0", perf_mem_stall); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_delayed();
    int reads = 0;
    int stalls = 0;
    set_in(1'b1, OP_LOAD, 3'd2, 5'd5, 1'b0, 32'h100);
    for (int i = 0; i < 4; i++) begin
      dmem.data_mem_resp  = (i == 3);
      dmem.data_mem_rdata = (i == 3) ? 32'hDEADBEEF : 32'h0;
      #2;
      if (dmem.data_mem_read === 1'b1) reads++;
      if (stall_out === 1'b1) stalls++;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lw_wait_wbvalid cyc=%0d got=%b exp=0", i, wb_valid); end
      step();
    end
    idle();
    total++; if (reads !== 4) begin bad++; $display("FAIL lw_read_cycles got=%0d exp=4", reads); end
    total++; if (stalls !== 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=3", stalls); end
    total++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd5) begin bad++; $display("FAIL lw_wb got v=%b we=%b rd=%0d exp 1/1/5", wb_valid, wb_we, wb_rd); end
    total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", wb_data); end
    total++; if (perf_mem_stall !== 2'd3) begin bad++; $display("FAIL lw_perf got=%0d exp=3", perf_mem_stall); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lw_pulse got=%b exp=0", wb_valid); end
  endtask

  task automatic test_extract();
    logic [2:0]  f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [1:0]  off [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    dmem.data_mem_resp  = 1'b1;
    dmem.data_mem_rdata = 32'h80FF7F01;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, OP_LOAD, f3[i], 5'd7, 1'b0, {30'h10, off[i]});
      #2;
      total++; if (stall_out !== 1'b0 || dmem.data_mem_read !== 1'b1) begin bad++; $display("FAIL ext_strobe i=%0d got stall=%b rd=%b exp 0/1", i, stall_out, dmem.data_mem_read); end
      step();
      total++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== exp[i]) begin bad++; $display("FAIL ext_data i=%0d got v=%b we=%b d=%h exp 1/1/%h", i, wb_valid, wb_we, wb_data, exp[i]); end
    end
    idle();
    total++; if (perf_mem_stall !== 2'd3) begin bad++; $display("FAIL ext_perf got=%0d exp=3", perf_mem_stall); end
  endtask

  task automatic test_store();
    int writes = 0;
    int reads = 0;
    set_in(1'b1, OP_STORE, 3'd2, 5'd9, 1'b0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      dmem.data_mem_resp = (i == 2);
      #2;
      if (dmem.data_mem_write === 1'b1) writes++;
      if (dmem.data_mem_read === 1'b1) reads++;
      step();
    end
    idle();
    total++; if (writes !== 3 || reads !== 0) begin bad++; $display("FAIL sw_strobes got w=%0d r=%0d exp 3/0", writes, reads); end
    total++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin bad++; $display("FAIL sw_wb got v=%b we=%b exp 1/0", wb_valid, wb_we); end
    total++; if (perf_mem_stall !== 2'd3) begin bad++; $display("FAIL sw_perf_sat got=%0d exp=3", perf_mem_stall); end
  endtask

  task automatic test_misalign();
    logic [6:0]  op  [4] = '{OP_LOAD, OP_STORE, OP_LOAD, OP_STORE};
    logic [2:0]  f3  [4] = '{3'd2, 3'd1, 3'd3, 3'd3};
    logic [31:0] adr [4] = '{32'h102, 32'h203, 32'h100, 32'h200};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, op[i], f3[i], 5'd5, 1'b1, adr[i]);
      #2;
      total++; if (dmem.data_mem_read !== 1'b0 || dmem.data_mem_write !== 1'b0 || stall_out !== 1'b0) begin bad++; $display("FAIL mis_strobe i=%0d got r=%b w=%b s=%b exp 000", i, dmem.data_mem_read, dmem.data_mem_write, stall_out); end
      step();
      total++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || misalign_err !== 1'b1) begin bad++; $display("FAIL mis_wb i=%0d got v=%b we=%b err=%b exp 1/0/1", i, wb_valid, wb_we, misalign_err); end
    end
    idle();
    step();
    total++; if (wb_valid !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL mis_pulse got v=%b err=%b exp 0/0", wb_valid, misalign_err); end
  endtask

  task automatic test_nonmem();
    set_in(1'b1, OP_ALU, 3'd0, 5'd0, 1'b1, 32'd7);
    step();
    total++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin bad++; $display("FAIL alu_rd0 got v=%b we=%b exp 1/0", wb_valid, wb_we); end
    set_in(1'b1, OP_ALU, 3'd0, 5'd3, 1'b1, 32'd7);
    step();
    total++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd7) begin bad++; $display("FAIL alu_rd3 got v=%b we=%b rd=%0d d=%h exp 1/1/3/7", wb_valid, wb_we, wb_rd, wb_data); end
    idle();
    step();
  endtask

  task automatic test_reset_stray();
    set_in(1'b1, OP_LOAD, 3'd2, 5'd5, 1'b0, 32'h100);
    step(); step();
    total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL rs_wait_stall got=%b exp=1", stall_out); end
    rst = 1'b1;
    #1;
    total++; if (dmem.data_mem_read !== 1'b0) begin bad++; $display("FAIL rs_read_drop got=%b exp=0", dmem.data_mem_read); end
    total++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || perf_mem_stall !== 2'd0) begin bad++; $display("FAIL rs_outputs got v=%b rd=%0d d=%h p=%0d exp zeros", wb_valid, wb_rd, wb_data, perf_mem_stall); end
    step();
    idle();
    rst = 1'b0;
    dmem.data_mem_resp = 1'b1;
    #2;
    total++; if (dmem.data_mem_read !== 1'b0 || stall_out !== 1'b0) begin bad++; $display("FAIL rs_stray_strobe got r=%b s=%b exp 0/0", dmem.data_mem_read, stall_out); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rs_stray_wb got=%b exp=0", wb_valid); end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, OP_LOAD, 3'd2, 5'd1, 1'b0, 32'h40);
    dmem.data_mem_resp = 1'b0;
    step();
    dmem.data_mem_resp = 1'b1; dmem.data_mem_rdata = 32'h11112222;
    step();
    set_in(1'b1, OP_LOAD, 3'd2, 5'd2, 1'b0, 32'h44);
    dmem.data_mem_resp = 1'b0;
    #2;
    total++; if (dmem.data_mem_read !== 1'b1 || stall_out !== 1'b1) begin bad++; $display("FAIL b2b_strobe got r=%b s=%b exp 1/1", dmem.data_mem_read, stall_out); end
    total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h11112222) begin bad++; $display("FAIL b2b_first got v=%b rd=%0d d=%h exp 1/1/11112222", wb_valid, wb_rd, wb_data); end
    step();
    dmem.data_mem_resp = 1'b1; dmem.data_mem_rdata = 32'h33334444;
    step();
    idle();
    total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h33334444) begin bad++; $display("FAIL b2b_second got v=%b rd=%0d d=%h exp 1/2/33334444", wb_valid, wb_rd, wb_data); end
    total++; if (perf_mem_stall !== 2'd2) begin bad++; $display("FAIL b2b_perf got=%0d exp=2", perf_mem_stall); end
  endtask

  initial begin
    test_reset();
    test_load_delayed();
    test_extract();
    test_store();
    test_misalign();
    test_nonmem();
    test_reset_stray();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
